scan_order_generator: RTL and testbench
=======================================

Name: scan_order_generator

Overview:
- Computes HEVC coefficient scan order on the fly from coordinate arithmetic, replacing per-size ROM tables.
- Hierarchical order: 4x4 coefficient groups (CGs) are scanned in scan_type order over the CG grid, and coefficients inside each CG in the same order.
- Supports non-square blocks up to 2^MAX_LOG2 per side, forward or reverse direction, and reverse start from the last significant coefficient.
- Feeds the RDOQ coefficient pipeline over a valid/ready stream.

Parameters:
- MAX_LOG2, 5, maximum log2 block side (legal block sides 4..2^MAX_LOG2).
- ADDR_W, 2*MAX_LOG2, width of the index and address outputs (derived; do not override).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- start  in  1  one-cycle request; sampled only in IDLE
- log2_w  in  3  log2 block width
- log2_h  in  3  log2 block height
- scan_type  in  2  0=up-right diagonal, 1=horizontal, 2=vertical, 3=illegal
- reverse  in  1  0=forward from index 0; 1=reverse from (last_x,last_y) down to index 0
- last_x  in  MAX_LOG2  last significant column (reverse only)
- last_y  in  MAX_LOG2  last significant row (reverse only)
- busy  out  1  high in SEEK/EMIT
- done  out  1  one-cycle pulse after the final handshake
- err  out  1  one-cycle pulse on illegal configuration
- out_valid  out  1  stream valid
- out_ready  in  1  stream ready
- out_index  out  ADDR_W  scan index of the current coefficient
- out_addr  out  ADDR_W  raster address y*W+x
- out_x  out  MAX_LOG2  column
- out_y  out  MAX_LOG2  row
- out_cg_index  out  ADDR_W-4  CG scan index (out_index>>4)
- out_cg_first  out  1  first coefficient emitted in the current CG
- out_last  out  1  final coefficient of the job

Behaviour:
- Reset: all outputs go to 0 on the next edge and state becomes IDLE. Reset mid-job aborts with no done.
- Accepting a job: on start in IDLE, latch all configuration inputs.
  - Illegal when log2_w or log2_h is outside 2..MAX_LOG2, scan_type==3, or (reverse and last_x>=W or last_y>=H).
  - Illegal: err pulses the next cycle, no emission, state stays IDLE.
  - start in any other state is ignored.
- States:
  - IDLE -> SEEK on a legal start.
  - SEEK advances one forward step per cycle from index 0 and stops when position equals the target: index 0 for forward, (last_x,last_y) for reverse. Then -> EMIT.
  - EMIT -> DONE on the handshake of the out_last element.
  - DONE pulses done for one cycle -> IDLE.
- Latency: first out_valid is asserted exactly k+1 cycles after the start edge, where k is the scan index of the target (k=0 for forward).
- Stepping on a Wg x Hg grid (Wg=W/4, Hg=H/4 for CGs; 4x4 within a CG):
  - Diagonal forward: if y==0 or x==Wg-1, go to the next diagonal d+1 at y=min(d+1,Hg-1), x=d+1-y; else x+1, y-1.
  - Diagonal reverse: if x==0 or y==Hg-1, go to the previous diagonal d-1 at x=min(d-1,Wg-1), y=d-1-x; else x-1, y+1.
  - Horizontal: row-major. Vertical: column-major.
  - The CG position steps only when the within-CG position wraps (15->0 forward, 0->15 reverse).
- out_index increments (forward) or decrements (reverse) by 1 per handshake.
- out_last: forward when index==W*H-1; reverse when index==0.
- out_cg_first: set on the first element of the job, and on every element following a CG step.
- Stream: outputs are registered. While out_valid && !out_ready, all out_* are held stable. The generator advances exactly one element per handshake; 1 element/cycle is sustained when out_ready is held high.
- Single-element job (reverse, last=(0,0)): one element, out_last=1, then done.
- done and out_valid are never high in the same cycle.

Test Plan:
- 4x4 diagonal forward, out_ready=1 -> out_addr sequence 0,4,1,8,5,2,12,9,6,3,13,10,7,14,11,15; out_valid first high 1 cycle after start; done 1 cycle after the index-15 handshake.
- 8x8 horizontal forward -> indices 0..15 give addrs 0,1,2,3,8,9,10,11,16,...,27; index 16 gives addr 4, out_cg_index=1, out_cg_first=1.
- 8x8 diagonal reverse, last=(1,0) -> k=2; out_valid first high 3 cycles after start; emits addr 1,8,0 with out_index 2,1,0; out_last on index 0.
- 32x8 vertical forward -> 256 elements; final element out_index=255, addr=255 (x=31,y=7), out_last=1.
- Backpressure: drop out_ready for 3 cycles mid-stream -> all out_* stable; no element skipped or duplicated.
- scan_type=3, or log2_w=6 with MAX_LOG2=5 -> err pulses, out_valid stays 0, busy stays 0. Separately, rst asserted mid-EMIT -> all outputs 0 next edge, no done pulse.

Source files
------------

// File: rtl/scan_order_generator_if.sv
// scan_order_generator_if: coefficient stream carrying scan index, position and CG markers.
interface scan_order_generator_if #(
    parameter int MAX_LOG2 = 5,
    parameter int ADDR_W = 2 * MAX_LOG2
);
    logic                out_valid;
    logic                out_ready;
    logic [ADDR_W-1:0]   out_index;
    logic [ADDR_W-1:0]   out_addr;
    logic [MAX_LOG2-1:0] out_x;
    logic [MAX_LOG2-1:0] out_y;
    logic [ADDR_W-5:0]   out_cg_index;
    logic                out_cg_first;
    logic                out_last;
    modport master (
        output out_valid, out_index, out_addr, out_x, out_y, out_cg_index, out_cg_first, out_last,
        input  out_ready
    );
    modport slave (
        input  out_valid, out_index, out_addr, out_x, out_y, out_cg_index, out_cg_first, out_last,
        output out_ready
    );
endinterface

// File: rtl/scan_order_generator.sv
// scan_order_generator: HEVC coefficient scan order from coordinate arithmetic (CG-hierarchical).
module scan_order_generator #(
    parameter int MAX_LOG2 = 5
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [2:0]          log2_w,
    input  logic [2:0]          log2_h,
    input  logic [1:0]          scan_type,
    input  logic                reverse,
    input  logic [MAX_LOG2-1:0] last_x,
    input  logic [MAX_LOG2-1:0] last_y,
    output logic                busy,
    output logic                done,
    output logic                err,
    scan_order_generator_if.master so
);
    localparam int P = MAX_LOG2;
    localparam int ADDR_W = 2 * MAX_LOG2;
    typedef enum logic [1:0] {IDLE, SEEK, EMIT, DONE} state_t;
    typedef struct packed {
        state_t            st;
        logic [2:0]        lw;
        logic [2:0]        lh;
        logic [1:0]        scan;
        logic              rev;
        logic [P-1:0]      tx;
        logic [P-1:0]      ty;
        logic [P-1:0]      x;
        logic [P-1:0]      y;
        logic [ADDR_W-1:0] idx;
        logic              valid;
        logic              cgf;
        logic              done;
        logic              err;
    } regs_t;

    regs_t r_q, r_d;
    logic [P-1:0] wgm1, hgm1, in_nx, in_ny, cg_nx, cg_ny, nxt_x, nxt_y;
    logic [ADDR_W:0] total;
    logic dir, in_wr, last, bad;

    // One step on a grid with max coordinates (wm1,hm1); the last/first cell wraps to the other end.
    function automatic logic [2*P-1:0] step(input logic [P-1:0] x, y, wm1, hm1,
                                            input logic [1:0] st, input logic rv);
        logic [P:0] d;
        logic [P-1:0] nx, ny;
        d = {1'b0, x} + {1'b0, y};
        nx = x;
        ny = y;
        if (rv ? (x == '0 && y == '0) : (x == wm1 && y == hm1)) begin
            nx = rv ? wm1 : '0;
            ny = rv ? hm1 : '0;
        end else if (st == 2'd0 && !rv && (y == '0 || x == wm1)) begin
            d = d + 1'b1;
            ny = (d > {1'b0, hm1}) ? hm1 : d[P-1:0];
            nx = P'(d - {1'b0, ny});
        end else if (st == 2'd0 && !rv) begin
            nx = x + 1'b1;
            ny = y - 1'b1;
        end else if (st == 2'd0 && (x == '0 || y == hm1)) begin
            d = d - 1'b1;
            nx = (d > {1'b0, wm1}) ? wm1 : d[P-1:0];
            ny = P'(d - {1'b0, nx});
        end else if (st == 2'd0) begin
            nx = x - 1'b1;
            ny = y + 1'b1;
        end else if (st == 2'd1) begin
            nx = rv ? ((x == '0) ? wm1 : x - 1'b1) : ((x == wm1) ? '0 : x + 1'b1);
            ny = rv ? ((x == '0) ? y - 1'b1 : y) : ((x == wm1) ? y + 1'b1 : y);
        end else begin
            ny = rv ? ((y == '0) ? hm1 : y - 1'b1) : ((y == hm1) ? '0 : y + 1'b1);
            nx = rv ? ((y == '0) ? x - 1'b1 : x) : ((y == hm1) ? x + 1'b1 : x);
        end
        return {nx, ny};
    endfunction

    always_comb begin
        dir = r_q.st == EMIT && r_q.rev;
        wgm1 = P'((32'd1 << (r_q.lw - 3'd2)) - 32'd1);
        hgm1 = P'((32'd1 << (r_q.lh - 3'd2)) - 32'd1);
        in_wr = dir ? (r_q.x[1:0] == 2'd0 && r_q.y[1:0] == 2'd0)
                    : (r_q.x[1:0] == 2'd3 && r_q.y[1:0] == 2'd3);
        {in_nx, in_ny} = step(r_q.x & P'(3), r_q.y & P'(3), P'(3), P'(3), r_q.scan, dir);
        {cg_nx, cg_ny} = step(r_q.x >> 2, r_q.y >> 2, wgm1, hgm1, r_q.scan, dir);
        // The CG coordinate only moves when the in-CG walk wraps around.
        nxt_x = in_wr ? ((cg_nx << 2) | in_nx) : ((r_q.x & ~P'(3)) | in_nx);
        nxt_y = in_wr ? ((cg_ny << 2) | in_ny) : ((r_q.y & ~P'(3)) | in_ny);
        total = (ADDR_W + 1)'(1) << ({1'b0, r_q.lw} + {1'b0, r_q.lh});
        last = r_q.valid && (r_q.rev ? r_q.idx == '0 : {1'b0, r_q.idx} == total - 1'b1);
        bad = log2_w < 3'd2 || log2_w > 3'(P) || log2_h < 3'd2 || log2_h > 3'(P) ||
              scan_type == 2'd3 ||
              (reverse && ({1'b0, last_x} >= ((P + 1)'(1) << log2_w) ||
                           {1'b0, last_y} >= ((P + 1)'(1) << log2_h)));
    end

    always_comb begin
        r_d = r_q;
        r_d.done = 1'b0;
        r_d.err = 1'b0;
        case (r_q.st)
            IDLE: begin
                if (start && bad) begin
                    r_d.err = 1'b1;
                end else if (start) begin
                    r_d.st = SEEK;
                    r_d.lw = log2_w;
                    r_d.lh = log2_h;
                    r_d.scan = scan_type;
                    r_d.rev = reverse;
                    r_d.tx = reverse ? last_x : '0;
                    r_d.ty = reverse ? last_y : '0;
                    r_d.x = '0;
                    r_d.y = '0;
                    r_d.idx = '0;
                end
            end
            SEEK: begin
                if (r_q.x == r_q.tx && r_q.y == r_q.ty) begin
                    r_d.st = EMIT;
                    r_d.valid = 1'b1;
                    r_d.cgf = 1'b1;
                end else begin
                    r_d.x = nxt_x;
                    r_d.y = nxt_y;
                    r_d.idx = r_q.idx + 1'b1;
                end
            end
            EMIT: begin
                if (so.out_ready && last) begin
                    r_d.st = DONE;
                    r_d.valid = 1'b0;
                    r_d.cgf = 1'b0;
                    r_d.done = 1'b1;
                end else if (so.out_ready) begin
                    r_d.x = nxt_x;
                    r_d.y = nxt_y;
                    r_d.idx = r_q.rev ? r_q.idx - 1'b1 : r_q.idx + 1'b1;
                    r_d.cgf = in_wr;
                end
            end
            default: r_d.st = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) r_q <= '0;
        else r_q <= r_d;
    end

    assign busy = r_q.st == SEEK || r_q.st == EMIT;
    assign done = r_q.done;
    assign err = r_q.err;
    assign so.out_valid = r_q.valid;
    assign so.out_index = r_q.idx;
    assign so.out_addr = (ADDR_W'(r_q.y) << r_q.lw) | ADDR_W'(r_q.x);
    assign so.out_x = r_q.x;
    assign so.out_y = r_q.y;
    assign so.out_cg_index = r_q.idx[ADDR_W-1:4];
    assign so.out_cg_first = r_q.cgf;
    assign so.out_last = last;
endmodule

// File: tb/tb_scan_order_generator.sv
// tb_scan_order_generator: scoreboard bench; reference scan built from explicit per-grid orderings.
module tb_scan_order_generator;
    typedef int iq_t[$];
    typedef struct packed {
        logic [9:0] idx;
        logic [9:0] addr;
        logic [4:0] x;
        logic [4:0] y;
        logic [5:0] cg;
        logic       cgf;
        logic       last;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start = 1'b0;
    logic [2:0] log2_w = '0;
    logic [2:0] log2_h = '0;
    logic [1:0] scan_type = '0;
    logic reverse = 1'b0;
    logic [4:0] last_x = '0;
    logic [4:0] last_y = '0;
    logic busy, done, err;
    int tests = 0;
    int fails = 0;
    int hs_total = 0;
    int bp_at = -1;
    bit rand_rdy = 1'b0;
    exp_t q[$];

    scan_order_generator_if #(.MAX_LOG2(5)) so ();
    scan_order_generator #(.MAX_LOG2(5)) dut (
        .clk(clk), .rst(rst), .start(start), .log2_w(log2_w), .log2_h(log2_h),
        .scan_type(scan_type), .reverse(reverse), .last_x(last_x), .last_y(last_y),
        .busy(busy), .done(done), .err(err), .so(so)
    );

    always #5 clk = ~clk;

    function automatic exp_t actual();
        return {so.out_index, so.out_addr, so.out_x, so.out_y, so.out_cg_index,
                so.out_cg_first, so.out_last};
    endfunction

    task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
        tests++;
        if (a !== e) begin
            fails++;
            $display("FAIL %s: actual=%0h required=%0h", n, a, e);
        end
    endtask

    // Cells of a w x h grid in scan order, encoded y*64+x.
    function automatic iq_t grid(input int w, input int h, input int st);
        iq_t r;
        if (st == 0) begin
            for (int d = 0; d <= w + h - 2; d++)
                for (int y = h - 1; y >= 0; y--)
                    if (y <= d && d - y < w) r.push_back(y * 64 + d - y);
        end else if (st == 1) begin
            for (int y = 0; y < h; y++) for (int x = 0; x < w; x++) r.push_back(y * 64 + x);
        end else begin
            for (int x = 0; x < w; x++) for (int y = 0; y < h; y++) r.push_back(y * 64 + x);
        end
        return r;
    endfunction

    task automatic build(input int lw, lh, st, rv, lx, ly, output int k);
        int w, h, n, i, prev;
        iq_t cgq, inq, pos;
        exp_t e;
        w = 1 << lw;
        h = 1 << lh;
        n = w * h;
        k = 0;
        prev = 0;
        cgq = grid(w / 4, h / 4, st);
        inq = grid(4, 4, st);
        foreach (cgq[c]) foreach (inq[j])
            pos.push_back((cgq[c] / 64 * 4 + inq[j] / 64) * 64 + (cgq[c] % 64) * 4 + inq[j] % 64);
        if (rv != 0) foreach (pos[j]) if (pos[j] == ly * 64 + lx) k = j;
        for (int j = 0; j <= ((rv != 0) ? k : n - 1); j++) begin
            i = (rv != 0) ? k - j : j;
            e.idx = 10'(i);
            e.x = 5'(pos[i] % 64);
            e.y = 5'(pos[i] / 64);
            e.addr = 10'((pos[i] / 64) * w + pos[i] % 64);
            e.cg = 6'(i / 16);
            e.cgf = (j == 0) || (i / 16 != prev / 16);
            e.last = (rv != 0) ? (i == 0) : (i == n - 1);
            q.push_back(e);
            prev = i;
        end
    endtask

    task automatic run_job(input int lw, lh, st, rv, lx, ly, input bit glitch, input bit rst_mid);
        int k, n;
        bit legal;
        k = 0;
        legal = lw >= 2 && lw <= 5 && lh >= 2 && lh <= 5 && st != 3 &&
                !(rv != 0 && (lx >= (1 << lw) || ly >= (1 << lh)));
        if (legal) build(lw, lh, st, rv, lx, ly, k);
        @(posedge clk); #1;
        start = 1'b1;
        log2_w = 3'(lw);
        log2_h = 3'(lh);
        scan_type = 2'(st);
        reverse = rv[0];
        last_x = 5'(lx);
        last_y = 5'(ly);
        @(posedge clk); #1;
        start = 1'b0;
        @(negedge clk);
        if (!legal) begin
            chk("err_pulse", {err, so.out_valid, busy}, 3'b100);
            repeat (2) begin
                @(negedge clk);
                chk("err_quiet", {err, so.out_valid, busy, done}, 4'b0);
            end
            return;
        end
        chk("busy_on_start", {busy, err}, 2'b10);
        n = 0;
        while (!so.out_valid && n < 3000) begin
            @(negedge clk);
            n++;
        end
        if (!so.out_valid) begin
            chk("valid_timeout", 0, 1);
            q.delete();
            return;
        end
        chk("latency", n, k + 1);
        if (rst_mid) begin
            repeat (5) @(negedge clk);
            @(posedge clk); #1;
            rst = 1'b1;
            @(posedge clk);
            @(negedge clk);
            chk("rst_zero", {so.out_valid, busy, done, err, actual()}, 0);
            @(posedge clk); #1;
            rst = 1'b0;
            q.delete();
            repeat (4) begin
                @(negedge clk);
                chk("rst_idle", {busy, done, so.out_valid}, 0);
            end
            return;
        end
        if (glitch) begin
            @(posedge clk); #1;
            start = 1'b1;
            scan_type = 2'd3;
            @(posedge clk); #1;
            start = 1'b0;
            @(negedge clk);
            chk("start_ignored", {err, busy}, 2'b01);
        end
        n = 0;
        while (!done && n < 6000) begin
            @(negedge clk);
            n++;
        end
        if (!done) chk("done_timeout", 0, 1);
        else chk("queue_drained", q.size(), 0);
        q.delete();
    endtask

    initial begin
        int drop, seen;
        drop = 0;
        seen = -1;
        so.out_ready = 1'b1;
        forever begin
            @(posedge clk); #1;
            if (bp_at >= 0 && bp_at != seen && hs_total >= bp_at) begin
                drop = 3;
                seen = bp_at;
            end
            if (drop > 0) begin
                so.out_ready = 1'b0;
                drop--;
            end else so.out_ready = rand_rdy ? ($urandom_range(0, 3) != 0) : 1'b1;
        end
    end

    initial begin
        exp_t saved, e;
        bit stall, last_hs, hs;
        stall = 1'b0;
        last_hs = 1'b0;
        saved = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                stall = 1'b0;
                last_hs = 1'b0;
            end else begin
                chk("done_timing", {done, done & so.out_valid}, {last_hs, 1'b0});
                if (stall) chk("hold_stable", {so.out_valid, actual()}, {1'b1, saved});
                hs = so.out_valid && so.out_ready;
                if (hs && q.size() == 0) chk("unexpected_element", 1, 0);
                else if (hs) begin
                    e = q.pop_front();
                    chk("element", actual(), e);
                    hs_total++;
                end
                last_hs = hs && so.out_last;
                stall = so.out_valid && !so.out_ready;
                saved = actual();
            end
        end
    end

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_state", {so.out_valid, busy, done, err, actual()}, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        run_job(2, 2, 0, 0, 0, 0, 1'b0, 1'b0);
        run_job(3, 3, 1, 0, 0, 0, 1'b0, 1'b0);
        run_job(3, 3, 0, 1, 1, 0, 1'b0, 1'b0);
        bp_at = hs_total + 100;
        run_job(5, 3, 2, 0, 0, 0, 1'b1, 1'b0);
        run_job(3, 2, 1, 1, 0, 0, 1'b0, 1'b0);
        run_job(5, 5, 2, 1, 17, 29, 1'b0, 1'b0);
        run_job(3, 3, 3, 0, 0, 0, 1'b0, 1'b0);
        run_job(6, 3, 0, 0, 0, 0, 1'b0, 1'b0);
        run_job(3, 1, 1, 0, 0, 0, 1'b0, 1'b0);
        run_job(2, 3, 0, 1, 4, 0, 1'b0, 1'b0);
        run_job(4, 4, 0, 0, 0, 0, 1'b0, 1'b1);
        rand_rdy = 1'b1;
        repeat (12) begin
            int lw, lh;
            lw = $urandom_range(2, 5);
            lh = $urandom_range(2, 5);
            run_job(lw, lh, $urandom_range(0, 2), $urandom_range(0, 1),
                    $urandom_range(0, (1 << lw) - 1), $urandom_range(0, (1 << lh) - 1), 1'b0, 1'b0);
        end
        rand_rdy = 1'b0;
        repeat (3) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
